uart_port_arbiter: RTL and testbench
====================================

# uart_port_arbiter

- Shares one simpleuart data port between `NREQ` byte-stream requesters on the TX side.
- Delivers received bytes to a single consumer stream on the RX side.
- TX uses round-robin arbitration with packet locking: a grant is held until the requester's `last` byte, or until an idle timeout expires.
- Sits between the SoC peripheral masters (console, debug monitor, boot loader) and the UART `reg_dat_*` port. The divider port stays with the CPU bus.

## Interface
Parameters:
- `NREQ`, 4 — number of TX requesters, 2..8.
- `TIMEOUT`, 1024 — LOAD-state idle cycles before the lock is dropped; 0 disables the timeout.

Ports:
- `clk` in 1 — single clock.
- `resetn` in 1 — reset, synchronous, active-low.
- `req_valid` in NREQ — requester i has a byte.
- `req_data` in 8*NREQ — byte of requester i at bits [8i+7:8i].
- `req_last` in NREQ — byte is the last of its packet.
- `req_ready` out NREQ — one-hot handshake pulse; byte consumed.
- `grant_id` out 3 — current owner, valid while `busy`.
- `busy` out 1 — lock held (state ≠ IDLE).
- `uart_dat_we` out 1 — UART write strobe.
- `uart_dat_di` out 32 — `{24'b0, tx_hold}`.
- `uart_dat_wait` in 1 — UART not ready; the write is accepted in the cycle where `we` is high and `wait` is low.
- `uart_dat_re` out 1 — read pulse; pops the UART receive buffer.
- `uart_dat_do` in 32 — `32'hFFFF_FFFF` means empty; otherwise `{24'b0, byte}`.
- `rx_valid` out 1 — received byte available.
- `rx_data` out 8 — received byte.
- `rx_ready` in 1 — consumer accepts the byte.

## Operation
TX FSM:
- **IDLE**
  - If any `req_valid`, pick the first set bit searching upward from `rr_ptr` (wrap mod NREQ).
  - Latch it into `grant_id` → LOAD.
  - If none is set, stay in IDLE.
- **LOAD**
  - If `req_valid[g]`: latch `req_data[g]` into `tx_hold` and `req_last[g]` into `hold_last`, pulse `req_ready[g]` this cycle → WRITE. Clear `idle_cnt`.
  - Else increment `idle_cnt`. When `TIMEOUT != 0` and `idle_cnt == TIMEOUT-1`: set `rr_ptr <= g+1`, go to IDLE.
- **WRITE**
  - Hold `uart_dat_we = 1` and `uart_dat_di` stable.
  - On the accept cycle (`!uart_dat_wait`): if `hold_last`, set `rr_ptr <= (g+1) mod NREQ` → IDLE; else → LOAD.
- A requester that is the only valid one is re-granted after its packet ends. No requester waits for more than NREQ-1 packets.

RX path:
- Capture condition: `!rx_valid`, `uart_dat_do[31:8] == 0`, and `uart_dat_re` low in the current cycle (guard cycle).
- On capture: `rx_data <= uart_dat_do[7:0]`, `rx_valid <= 1`, `uart_dat_re <= 1` for exactly one cycle.
- The guard cycle prevents double capture of a byte still visible while the UART clears its valid flag.
- `rx_valid` clears on `rx_valid && rx_ready`. There is no recapture in that same cycle.
- A received `8'hFF` is valid because it appears as `32'h0000_00FF`.

## Timing
Reset values:
- `req_ready=0`, `grant_id=0`, `busy=0`, `uart_dat_we=0`, `uart_dat_di=0`, `uart_dat_re=0`, `rx_valid=0`, `rx_data=0`.
- Internal: `rr_ptr=0`, state IDLE, `idle_cnt=0`.

TX timing:
- Byte latency from `req_valid` (already locked) to `uart_dat_we`: 1 cycle.
- From IDLE: 2 cycles.
- Back-to-back bytes: LOAD ↔ WRITE, so at least 2 cycles per byte. The UART bit time dominates.

Reset and outputs:
- Reset mid-packet aborts immediately. A byte already handshaken but not yet written is dropped.
- `req_ready` and `uart_dat_re` are registered pulses, never high for 2 consecutive cycles from the same event.

Other timing rules:
- RX capture to `rx_valid`: 1 cycle. `rx_valid` holds until `rx_ready`.
- `idle_cnt` is `$clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.

## Structure
- Shared header `uart_arb_defs.vh`: state encodings `ST_IDLE=2'd0`, `ST_LOAD=2'd1`, `ST_WRITE=2'd2`, and `UART_DAT_EMPTY=32'hFFFF_FFFF`.
- One sub-module, `rr_pick`: combinational, takes `NREQ`, `req` vector and `ptr`, and returns `gnt_idx` and `any`. It is reused for the future interrupt-source arbiter.
- The RX path stays inline: a small register stage, no sub-module.

## Test plan
- **Single packet:** req0 sends `8'h41, 8'h42 (last)`.
  - UART sees `we` with `di=32'h41` held while `wait` is high, then `32'h42`.
  - `req_ready[0]` pulses twice. `busy` falls 1 cycle after the last accept.
- **Round robin:** req0–3 all valid with 1-byte packets.
  - Write order is 0,1,2,3,0.
  - After reset with only req2 valid, the order is 2,2 (re-grant).
- **Lock:** req1 sends a 3-byte packet while req0 raises valid mid-packet.
  - All 3 req1 bytes go out contiguously, then req0.
- **Timeout:** `TIMEOUT=8`; req3 sends 1 non-last byte, then drops valid.
  - After 8 LOAD cycles the state returns to IDLE, `rr_ptr=0`, and a pending req0 is granted.
- **RX:** `uart_dat_do` goes from `FFFF_FFFF` to `0000_00FF`, holding for 2 cycles.
  - `uart_dat_re` pulses once and `rx_valid=1` with `rx_data=8'hFF`.
  - With `rx_ready` held low, a second byte is not captured until the first is popped.
- **Reset mid-WRITE:** `resetn` is low for 1 cycle while `we=1`.
  - The next cycle shows `we=0`, `busy=0`, `rx_valid=0`, and `rr_ptr` back to 0.

Source files
------------

// File: rtl/uart_port_arbiter_pkg.sv
// Shared types and constants for the UART data-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2
  } tx_state_t;

  localparam logic [31:0] UART_DAT_EMPTY = 32'hFFFF_FFFF;

  // Round-robin successor of a requester index.
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input int nreq);
    return (int'(idx) == nreq - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_port_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping mod NREQ.
// Latency: combinational.
// Backpressure: none; ptr must be below NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      gnt_idx,
  output logic            any
);

  function automatic int wrap(input int s);
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[wrap(int'(ptr) + off)]) gnt_idx = 3'(wrap(int'(ptr) + off));
    end
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares the simpleuart data port among NREQ TX streams; forwards RX bytes to one consumer.
// Latency: TX 2 cycles from idle, 1 cycle when locked; RX 1 cycle from capture to rx_valid.
// Backpressure: TX stalls on uart_dat_wait; RX holds one byte until rx_ready, UART is not popped meanwhile.
module uart_port_arbiter
  import uart_port_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                uart_dat_we,
  output logic [31:0]         uart_dat_di,
  input  logic                uart_dat_wait,
  output logic                uart_dat_re,
  input  logic [31:0]         uart_dat_do,
  output logic                rx_valid,
  output logic [7:0]          rx_data,
  input  logic                rx_ready
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  tx_state_t     state, state_nxt;
  logic [2:0]    rr_ptr;
  logic [7:0]    tx_hold;
  logic          hold_last;
  logic [CW-1:0] idle_cnt;
  logic [2:0]    pick_idx;
  logic          pick_any;
  logic          gnt_valid;
  logic          timeout_hit;
  logic          accept;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign gnt_valid   = req_valid[grant_id];
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == CNT_LAST);
  assign accept      = !uart_dat_wait;
  assign uart_dat_di = {24'd0, tx_hold};

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (gnt_valid)        state_nxt = ST_WRITE;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_WRITE: if (accept) state_nxt = hold_last ? ST_IDLE : ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    uart_dat_we = (state == ST_WRITE);
  end

  // req_ready is registered, so it pulses in the first WRITE cycle after the byte is latched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      tx_hold   <= '0;
      hold_last <= 1'b0;
      idle_cnt  <= '0;
      req_ready <= '0;
    end else begin
      req_ready <= '0;
      if (state != ST_LOAD) idle_cnt <= '0;
      case (state)
        ST_IDLE: if (pick_any) grant_id <= pick_idx;
        ST_LOAD: begin
          if (gnt_valid) begin
            tx_hold   <= req_data[8*grant_id +: 8];
            hold_last <= req_last[grant_id];
            req_ready <= NREQ'(1) << grant_id;
            idle_cnt  <= '0;
          end else begin
            if (idle_cnt != '1) idle_cnt <= idle_cnt + CW'(1);
            if (timeout_hit)    rr_ptr   <= next_idx(grant_id, NREQ);
          end
        end
        ST_WRITE: if (accept && hold_last) rr_ptr <= next_idx(grant_id, NREQ);
        default: ;
      endcase
    end
  end

  // A byte stays visible on uart_dat_do for the cycle after the pop; the re guard skips it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      uart_dat_re <= 1'b0;
    end else begin
      uart_dat_re <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else if (!rx_valid && !uart_dat_re && uart_dat_do[31:8] == 24'd0) begin
        rx_data     <= uart_dat_do[7:0];
        rx_valid    <= 1'b1;
        uart_dat_re <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: randomized packet streams and RX bytes against a packet-level model.
// Latency: n/a.
// Backpressure: random uart_dat_wait and rx_ready stalls.
module tb_uart_port_arbiter;
  import uart_port_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 1024;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        grant_id;
  logic              busy;
  logic              uart_dat_we;
  logic [31:0]       uart_dat_di;
  logic              uart_dat_wait;
  logic              uart_dat_re;
  logic [31:0]       uart_dat_do;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;

  always #5 clk = ~clk;

  uart_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .uart_dat_re   (uart_dat_re),
    .uart_dat_do   (uart_dat_do),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Requester byte streams ({last, byte}) and the model's own copy of them.
  logic [8:0]  txmem [NREQ][DEPTH];
  int          thead [NREQ];
  int          ttail [NREQ];
  logic [8:0]  mmem  [NREQ][DEPTH];
  int          mhead [NREQ];
  int          mtail [NREQ];
  int          mptr;
  logic [10:0] tx_exp [$];
  logic [7:0]  rx_exp [$];
  logic [7:0]  uart_rxq [$];
  logic        pop_pending;
  logic        wait_rand, wait_force, rdy_rand, rdy_force;
  int          rdy_cnt [NREQ];
  int          re_cnt;
  logic [8:0]  cur;
  logic [10:0] exp_e;
  logic [7:0]  exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input logic last);
    txmem[r][ttail[r] % DEPTH] = {last, b};
    mmem[r][mtail[r] % DEPTH]  = {last, b};
    ttail[r]++;
    mtail[r]++;
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), k == len - 1);
  endtask

  // Packet-level round robin: each granted requester sends until its last byte
  // (or until its stream runs dry, which ends in a timeout), then the pointer moves past it.
  task automatic model_drain();
    int pick;
    logic [8:0] e;
    logic done;
    do begin
      pick = -1;
      for (int k = 0; k < NREQ; k++)
        if (pick < 0 && mhead[(mptr + k) % NREQ] != mtail[(mptr + k) % NREQ]) pick = (mptr + k) % NREQ;
      if (pick >= 0) begin
        done = 1'b0;
        while (!done && mhead[pick] != mtail[pick]) begin
          e = mmem[pick][mhead[pick] % DEPTH];
          mhead[pick]++;
          tx_exp.push_back({3'(pick), e[7:0]});
          done = e[8];
        end
        mptr = (pick + 1) % NREQ;
      end
    end while (pick >= 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      thead[i] = 0; ttail[i] = 0; mhead[i] = 0; mtail[i] = 0; rdy_cnt[i] = 0;
    end
    mptr = 0;
    re_cnt = 0;
    tx_exp.delete();
    rx_exp.delete();
    uart_rxq.delete();
    pop_pending = 1'b0;
    repeat (cycles) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0 || busy) && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 4000) fail_bound(name);
    repeat (3) @(negedge clk);
  endtask

  // Requester, UART and consumer drivers, updated just after each active edge.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && thead[i] != ttail[i]) thead[i]++;
      if (thead[i] != ttail[i]) begin
        cur = txmem[i][thead[i] % DEPTH];
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = cur[7:0];
        req_last[i]         = cur[8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'd0;
        req_last[i]         = 1'b0;
      end
    end
    uart_dat_wait = wait_rand ? ($urandom_range(0, 2) == 0) : wait_force;
    rx_ready      = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    if (pop_pending && uart_rxq.size() > 0) void'(uart_rxq.pop_front());
    pop_pending = 1'b0;
    uart_dat_do = (uart_rxq.size() > 0) ? {24'd0, uart_rxq[0]} : UART_DAT_EMPTY;
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      if (uart_dat_we && !uart_dat_wait) begin
        if (tx_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_extra: byte %h from %0d, none expected", uart_dat_di, grant_id);
        end else begin
          exp_e = tx_exp.pop_front();
          check("tx_byte", uart_dat_di, {24'd0, exp_e[7:0]});
          check("tx_owner", 32'(grant_id), 32'(exp_e[10:8]));
        end
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_extra: byte %h, none expected", rx_data);
        end else begin
          exp_b = rx_exp.pop_front();
          check("rx_byte", 32'(rx_data), 32'(exp_b));
        end
      end
      if (uart_dat_re) pop_pending = 1'b1;
      for (int i = 0; i < NREQ; i++) rdy_cnt[i] += int'(req_ready[i]);
      re_cnt += int'(uart_dat_re);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int cnt;
    resetn = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    uart_dat_wait = 1'b0; uart_dat_do = UART_DAT_EMPTY; rx_ready = 1'b0;
    wait_rand = 1'b0; wait_force = 1'b0; rdy_rand = 1'b0; rdy_force = 1'b0;
    pop_pending = 1'b0;

    do_reset(3);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(uart_dat_we), 32'd0);
    check("rst_di", uart_dat_di, 32'd0);
    check("rst_re", 32'(uart_dat_re), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);

    // Single packet with the UART stalled on the first byte.
    wait_force = 1'b1;
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b1);
    model_drain();
    @(negedge clk);
    check("lat_busy_c0", 32'(busy), 32'd0);
    @(negedge clk);
    check("lat_busy_c1", 32'(busy), 32'd1);
    check("lat_we_c1", 32'(uart_dat_we), 32'd0);
    @(negedge clk);
    check("lat_we_c2", 32'(uart_dat_we), 32'd1);
    check("ready_pulse", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_we", 32'(uart_dat_we), 32'd1);
      check("hold_di", uart_dat_di, 32'h41);
      check("ready_single", 32'(req_ready), 32'd0);
    end
    wait_force = 1'b0;
    g = 0;
    while (!(uart_dat_we && !uart_dat_wait && uart_dat_di == 32'h42) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail_bound("single_last");
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("ready_count0", 32'(rdy_cnt[0]), 32'd2);
    drain("single");

    // Round robin over four 1-byte packets from reset, then single-requester re-grant.
    do_reset(2);
    for (int r = 0; r < NREQ; r++) add_pkt(r, 1);
    add_pkt(0, 1);
    model_drain();
    drain("round_robin");
    do_reset(2);
    add_pkt(2, 1);
    add_pkt(2, 1);
    model_drain();
    drain("regrant");

    // Lock: req0 appears in the middle of a 3-byte req1 packet.
    wait_rand = 1'b1;
    add_pkt(1, 3);
    model_drain();
    g = 0;
    while (!req_ready[1] && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail_bound("lock_start");
    add_pkt(0, 1);
    model_drain();
    drain("lock");
    wait_rand = 1'b0;

    // Timeout: req3 stops without a last byte; req0 and req1 wait behind it.
    push_byte(3, 8'h5A, 1'b0);
    model_drain();
    g = 0;
    while (!(busy && grant_id == 3'd3) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail_bound("timeout_grant");
    add_pkt(0, 1);
    add_pkt(1, 1);
    model_drain();
    g = 0;
    while (!(uart_dat_we && !uart_dat_wait && grant_id == 3'd3) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail_bound("timeout_write");
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_cycles", 32'(cnt), 32'(TIMEOUT));
    @(negedge clk);
    check("timeout_regrant", 32'(grant_id), 32'd0);
    drain("timeout");

    // RX: 8'hFF then 8'h12 with the consumer stalled.
    re_cnt = 0;
    uart_rxq.push_back(8'hFF);
    uart_rxq.push_back(8'h12);
    rx_exp.push_back(8'hFF);
    rx_exp.push_back(8'h12);
    repeat (8) @(negedge clk);
    check("rx_re_once", 32'(re_cnt), 32'd1);
    check("rx_valid_ff", 32'(rx_valid), 32'd1);
    check("rx_data_ff", 32'(rx_data), 32'hFF);
    rdy_force = 1'b1;
    drain("rx");
    check("rx_re_twice", 32'(re_cnt), 32'd2);
    check("rx_idle", 32'(rx_valid), 32'd0);
    rdy_force = 1'b0;

    // Randomized traffic on both paths.
    wait_rand = 1'b1;
    rdy_rand = 1'b1;
    for (int round = 0; round < 15; round++) begin
      for (int r = 0; r < NREQ; r++)
        for (int p = 0; p < $urandom_range(0, 2); p++) add_pkt(r, $urandom_range(1, 4));
      model_drain();
      for (int k = 0; k < $urandom_range(0, 4); k++) begin
        exp_b = (k == 0 && round % 3 == 0) ? 8'hFF : 8'($urandom);
        uart_rxq.push_back(exp_b);
        rx_exp.push_back(exp_b);
      end
      drain("random");
    end
    wait_rand = 1'b0;
    rdy_rand = 1'b0;

    // Reset in the middle of a stalled write, with an RX byte held.
    wait_force = 1'b0;
    add_pkt(1, 1);
    model_drain();
    drain("pre_reset");
    uart_rxq.push_back(8'h77);
    wait_force = 1'b1;
    add_pkt(1, 3);
    model_drain();
    g = 0;
    while (!uart_dat_we && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail_bound("mid_write");
    check("pre_rst_rx_valid", 32'(rx_valid), 32'd1);
    do_reset(1);
    check("mid_rst_we", 32'(uart_dat_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    wait_force = 1'b0;
    add_pkt(3, 1);
    add_pkt(0, 1);
    model_drain();
    drain("post_reset");

    check("tx_left", 32'(tx_exp.size()), 32'd0);
    check("rx_left", 32'(rx_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
